sram_march_bist_ctrl: RTL and testbench

- Self-contained March C- BIST sequencer for the single-port BIST-capable SRAM macros (default geometry 512x64).
- Drives the macro's A_BIST_* port set and compares the read data on A_DOUT against expected values.
- Reports pass/fail, the first failing address and element, and a saturating error count.
- Sits beside each SRAM instance and is started by the chip test controller.

---
 rtl/sram_march_bist_ctrl_if.sv | 37 +++
 rtl/sram_march_bist_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_sram_march_bist_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_march_bist_ctrl_if.sv
// Bus between the March C- BIST sequencer and its SRAM macro / chip test controller.
// The master side is the sequencer; the slave side is the macro plus the test controller.
interface sram_march_bist_ctrl_if #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 64,
  parameter int ERR_CNT_WIDTH = 8
) ();
  logic                     START;
  logic                     BUSY;
  logic                     DONE;
  logic                     FAIL;
  logic [ADDR_WIDTH-1:0]    FAIL_ADDR;
  logic [2:0]               FAIL_ELEM;
  logic [ERR_CNT_WIDTH-1:0] ERR_CNT;
  logic                     A_BIST_EN;
  logic                     A_BIST_MEN;
  logic                     A_BIST_WEN;
  logic                     A_BIST_REN;
  logic [ADDR_WIDTH-1:0]    A_BIST_ADDR;
  logic [DATA_WIDTH-1:0]    A_BIST_DIN;
  logic [DATA_WIDTH-1:0]    A_BIST_BM;
  logic [DATA_WIDTH-1:0]    A_DOUT;

  modport master (
    input  START, A_DOUT,
    output BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT,
           A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
           A_BIST_ADDR, A_BIST_DIN, A_BIST_BM
  );

  modport slave (
    output START, A_DOUT,
    input  BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT,
           A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
           A_BIST_ADDR, A_BIST_DIN, A_BIST_BM
  );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer: issues one SRAM operation per cycle over six March elements,
// compares each read one cycle later and records first-failure address/element plus a saturating count.
module sram_march_bist_ctrl #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 64,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                          A_CLK,
  input  logic                          A_RST,
  sram_march_bist_ctrl_if.master        bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  localparam logic [ADDR_WIDTH-1:0]    ADDR_LO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]    ADDR_HI  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Element M0 writes only, M5 reads only; M1..M4 read in phase 0 and write in phase 1.
  function automatic logic op_is_write(input logic [2:0] elem, input logic phase);
    logic w;
    case (elem)
      M0:                 w = 1'b1;
      M1, M2, M3, M4:     w = phase;
      M5:                 w = 1'b0;
      default:            w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic wr_pattern(input logic [2:0] elem);
    logic p;
    case (elem)
      M1, M3:  p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic rd_pattern(input logic [2:0] elem);
    logic p;
    case (elem)
      M2, M4:  p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic elem_is_down(input logic [2:0] elem);
    return (elem >= M3);
  endfunction

  logic [1:0]               state_q, state_d;
  logic [2:0]               elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     phase_q, phase_d;
  logic                     start_ok_s;
  logic                     issue_s;
  logic                     wr_s;
  logic                     last_op_s;
  logic                     two_op_s;
  logic [ADDR_WIDTH-1:0]    term_s;
  logic [2:0]               elem_nx_s;

  logic                     en_q, en_d;
  logic                     done_q, done_d;
  logic                     men_q, men_d;
  logic                     wen_q, wen_d;
  logic                     ren_q, ren_d;
  logic                     din_q, din_d;
  logic [ADDR_WIDTH-1:0]    op_addr_q, op_addr_d;

  logic                     cmp_vld_q, cmp_vld_d;
  logic                     cmp_exp_q, cmp_exp_d;
  logic [ADDR_WIDTH-1:0]    cmp_addr_q, cmp_addr_d;
  logic [2:0]               cmp_elem_q, cmp_elem_d;
  logic                     mismatch_s;

  logic                     fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]    fail_addr_q, fail_addr_d;
  logic [2:0]               fail_elem_q, fail_elem_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  assign last_op_s = (elem_q == M5) && (addr_q == ADDR_LO);
  assign two_op_s  = (elem_q != M0) && (elem_q != M5);
  assign term_s    = elem_is_down(elem_q) ? ADDR_LO : ADDR_HI;
  assign elem_nx_s = elem_q + 3'd1;

  // Sequencer: state transitions and the next operation to present
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    start_ok_s = 1'b0;
    issue_s    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d    = S_RUN;
          start_ok_s = 1'b1;
          issue_s    = 1'b1;
          elem_d     = M0;
          addr_d     = ADDR_LO;
          phase_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (last_op_s) begin
          state_d = S_DRAIN;
        end else begin
          issue_s = 1'b1;
          if (two_op_s && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (addr_q == term_s) begin
              // Down elements start at N-1, up elements at 0; no gap between elements.
              elem_d = elem_nx_s;
              addr_d = elem_is_down(elem_nx_s) ? ADDR_HI : ADDR_LO;
            end else if (elem_is_down(elem_q)) begin
              addr_d = addr_q - ADDR_ONE;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_s = op_is_write(elem_d, phase_d);

  // Registered SRAM strobes and status flags derived from the next state/operation
  always_comb begin
    en_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    men_d     = issue_s;
    wen_d     = issue_s && wr_s;
    ren_d     = issue_s && !wr_s;
    din_d     = issue_s && wr_s && wr_pattern(elem_d);
    op_addr_d = issue_s ? addr_d : ADDR_LO;
  end

  // Read-compare pipeline: capture expectation when the SRAM samples the read
  always_comb begin
    cmp_vld_d  = ren_q;
    cmp_exp_d  = rd_pattern(elem_q);
    cmp_addr_d = addr_q;
    cmp_elem_d = elem_q;
  end

  assign mismatch_s = cmp_vld_q && (bus.A_DOUT != {DATA_WIDTH{cmp_exp_q}});

  // Status: cleared on an accepted start, otherwise first-failure capture and saturating count
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    err_d       = err_q;
    if (start_ok_s) begin
      fail_d      = 1'b0;
      fail_addr_d = ADDR_LO;
      fail_elem_d = 3'd0;
      err_d       = {ERR_CNT_WIDTH{1'b0}};
    end else if (mismatch_s) begin
      err_d = (err_q == ERR_MAX) ? ERR_MAX : err_q + ERR_ONE;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end else begin
        fail_d = fail_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  // State, operation and status registers with synchronous reset
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q     <= S_IDLE;
      elem_q      <= M0;
      addr_q      <= ADDR_LO;
      phase_q     <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= 1'b0;
      op_addr_q   <= ADDR_LO;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= ADDR_LO;
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= ADDR_LO;
      fail_elem_q <= 3'd0;
      err_q       <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      en_q        <= en_d;
      done_q      <= done_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      op_addr_q   <= op_addr_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      err_q       <= err_d;
    end
  end

  assign bus.BUSY        = en_q;
  assign bus.DONE        = done_q;
  assign bus.FAIL        = fail_q;
  assign bus.FAIL_ADDR   = fail_addr_q;
  assign bus.FAIL_ELEM   = fail_elem_q;
  assign bus.ERR_CNT     = err_q;
  assign bus.A_BIST_EN   = en_q;
  assign bus.A_BIST_MEN  = men_q;
  assign bus.A_BIST_WEN  = wen_q;
  assign bus.A_BIST_REN  = ren_q;
  assign bus.A_BIST_ADDR = op_addr_q;
  assign bus.A_BIST_DIN  = {DATA_WIDTH{din_q}};
  assign bus.A_BIST_BM   = {DATA_WIDTH{en_q}};

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for the March C- BIST sequencer with behavioural SRAM models and injectable faults.
module tb_sram_march_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sram_march_bist_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(64), .ERR_CNT_WIDTH(8)) bif ();
  sram_march_bist_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8),  .ERR_CNT_WIDTH(8)) sif ();

  sram_march_bist_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(64), .ERR_CNT_WIDTH(8)) dut (
    .A_CLK(clk), .A_RST(rst), .bus(bif.master)
  );
  sram_march_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dut_s (
    .A_CLK(clk), .A_RST(rst), .bus(sif.master)
  );

  // ---------------- 512x64 SRAM model with fault injection and op log
  logic [63:0] mem [0:511];
  logic [63:0] dout = 64'd0;
  logic        stuck1_en = 1'b0;
  logic        stuck0_en = 1'b0;
  int men_cnt = 0, wen_cnt = 0, ren_cnt = 0;
  int both_cnt = 0, din_bad = 0, bm_bad = 0, strobe_bad = 0;
  int log_base = 0;
  logic       op_w [0:5119];
  logic [8:0] op_a [0:5119];
  logic       op_d [0:5119];

  assign bif.A_DOUT = dout;

  function automatic logic [63:0] faulty(input logic [63:0] d, input logic [8:0] a);
    logic [63:0] r;
    r = d;
    if (stuck1_en && a == 9'h1A3) r[5] = 1'b1;
    if (stuck0_en) r[0] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bif.A_BIST_MEN) begin
      men_cnt <= men_cnt + 1;
      if ((men_cnt - log_base) >= 0 && (men_cnt - log_base) < 5120) begin
        op_w[men_cnt - log_base] <= bif.A_BIST_WEN;
        op_a[men_cnt - log_base] <= bif.A_BIST_ADDR;
        op_d[men_cnt - log_base] <= bif.A_BIST_DIN[0];
      end
      if (bif.A_BIST_WEN) begin
        wen_cnt <= wen_cnt + 1;
        mem[bif.A_BIST_ADDR] <= (mem[bif.A_BIST_ADDR] & ~bif.A_BIST_BM) | (bif.A_BIST_DIN & bif.A_BIST_BM);
      end
      if (bif.A_BIST_REN) begin
        ren_cnt <= ren_cnt + 1;
        dout <= faulty(mem[bif.A_BIST_ADDR], bif.A_BIST_ADDR);
      end
    end
    if (bif.A_BIST_WEN && bif.A_BIST_REN) both_cnt <= both_cnt + 1;
    if ((bif.A_BIST_WEN || bif.A_BIST_REN) && !bif.A_BIST_MEN) strobe_bad <= strobe_bad + 1;
    if (bif.A_BIST_DIN !== {64{bif.A_BIST_DIN[0]}}) din_bad <= din_bad + 1;
    if (bif.A_BIST_BM !== (bif.A_BIST_EN ? {64{1'b1}} : 64'd0)) bm_bad <= bm_bad + 1;
  end

  // ---------------- 16x8 SRAM model for the small variant
  logic [7:0] mem_s [0:15];
  logic [7:0] dout_s = 8'd0;
  int men_s = 0;
  assign sif.A_DOUT = dout_s;

  always @(posedge clk) begin
    if (sif.A_BIST_MEN) begin
      men_s <= men_s + 1;
      if (sif.A_BIST_WEN) mem_s[sif.A_BIST_ADDR] <= sif.A_BIST_DIN;
      if (sif.A_BIST_REN) dout_s <= mem_s[sif.A_BIST_ADDR];
    end
  end

  // Start a run on the big DUT; returns edges from E0 to DONE (-1 on timeout).
  task automatic run_big(input int pulse_at, output int done_k, output int busy_bad,
                         output logic [23:0] stat0);
    int k;
    @(negedge clk);
    bif.START = 1'b1;
    @(posedge clk); #1;
    bif.START = 1'b0;
    k = 0;
    stat0 = {bif.DONE, bif.BUSY, bif.FAIL, bif.FAIL_ADDR, bif.FAIL_ELEM, bif.ERR_CNT};
    busy_bad = bif.BUSY ? 0 : 1;
    done_k = -1;
    while (k < 6000) begin
      @(posedge clk); #1;
      k++;
      if (k == pulse_at - 1) bif.START = 1'b1;
      if (k == pulse_at)     bif.START = 1'b0;
      if (bif.DONE) begin
        done_k = k;
        break;
      end
      if (!bif.BUSY) busy_bad++;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({bif.BUSY, bif.DONE, bif.FAIL, bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {bif.BUSY, bif.DONE, bif.FAIL, bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN});
    end
    total++;
    if ({bif.FAIL_ADDR, bif.FAIL_ELEM, bif.ERR_CNT, bif.A_BIST_ADDR} !== 29'd0) begin
      bad++; $display("FAIL reset_status: addr=%0h elem=%0d err=%0d opaddr=%0h want 0",
        bif.FAIL_ADDR, bif.FAIL_ELEM, bif.ERR_CNT, bif.A_BIST_ADDR);
    end
    total++;
    if ({bif.A_BIST_DIN, bif.A_BIST_BM} !== 128'd0) begin
      bad++; $display("FAIL reset_data: din=%h bm=%h want 0", bif.A_BIST_DIN, bif.A_BIST_BM);
    end
  endtask

  task automatic test_fault_free;
    int done_k, busy_bad, m0, w0, r0, b0, d0, bm0, s0, seq_bad, n, a;
    logic [23:0] st;
    m0 = men_cnt; w0 = wen_cnt; r0 = ren_cnt; b0 = both_cnt; d0 = din_bad; bm0 = bm_bad; s0 = strobe_bad;
    log_base = men_cnt;
    run_big(-10, done_k, busy_bad, st);
    total++; if (done_k != 5121) begin bad++; $display("FAIL ff_done_latency: got %0d want 5121", done_k); end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL ff_busy_low: got %0d want 0", busy_bad); end
    total++; if ({bif.BUSY, bif.A_BIST_EN} !== 2'b00) begin bad++; $display("FAIL ff_busy_at_done: got %b want 00", {bif.BUSY, bif.A_BIST_EN}); end
    total++; if (bif.FAIL !== 1'b0 || bif.ERR_CNT !== 8'd0) begin bad++; $display("FAIL ff_status: fail=%b err=%0d want 0 0", bif.FAIL, bif.ERR_CNT); end
    total++; if (men_cnt - m0 != 5120) begin bad++; $display("FAIL ff_men_count: got %0d want 5120", men_cnt - m0); end
    total++; if (wen_cnt - w0 != 2560 || ren_cnt - r0 != 2560) begin bad++; $display("FAIL ff_wr_rd_count: got %0d/%0d want 2560/2560", wen_cnt - w0, ren_cnt - r0); end
    total++; if (both_cnt != b0 || strobe_bad != s0) begin bad++; $display("FAIL ff_strobes: both=%0d orphan=%0d want 0", both_cnt - b0, strobe_bad - s0); end
    total++; if (bm_bad != bm0 || din_bad != d0) begin bad++; $display("FAIL ff_bm_din: bm=%0d din=%0d want 0", bm_bad - bm0, din_bad - d0); end
    total++; if (!(op_w[0] && op_a[0] == 9'd0 && !op_d[0] && op_w[511] && op_a[511] == 9'd511)) begin
      bad++; $display("FAIL ff_m0_writes: op0 w=%b a=%0d op511 w=%b a=%0d", op_w[0], op_a[0], op_w[511], op_a[511]); end
    total++; if (!(!op_w[512] && op_a[512] == 9'd0 && op_w[513] && op_a[513] == 9'd0 && op_d[513])) begin
      bad++; $display("FAIL ff_m1_start: op512 w=%b a=%0d op513 w=%b a=%0d d=%b", op_w[512], op_a[512], op_w[513], op_a[513], op_d[513]); end
    total++; if (!(!op_w[2560] && op_a[2560] == 9'd511 && !op_w[5119] && op_a[5119] == 9'd0)) begin
      bad++; $display("FAIL ff_m3_last: op2560 w=%b a=%0d op5119 w=%b a=%0d", op_w[2560], op_a[2560], op_w[5119], op_a[5119]); end
    // Full March C- reference sequence
    seq_bad = 0; n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < 512; j++) begin
        a = (e < 3) ? j : 511 - j;
        if (e == 0) begin
          if (!(op_w[n] && op_a[n] == a[8:0] && !op_d[n])) seq_bad++;
          n++;
        end else begin
          if (!(!op_w[n] && op_a[n] == a[8:0])) seq_bad++;
          n++;
          if (e < 5) begin
            if (!(op_w[n] && op_a[n] == a[8:0] && op_d[n] == ((e == 1) || (e == 3)))) seq_bad++;
            n++;
          end
        end
      end
    end
    total++; if (seq_bad != 0) begin bad++; $display("FAIL ff_op_sequence: got %0d wrong ops want 0", seq_bad); end
  endtask

  task automatic test_stuck1;
    int done_k, busy_bad;
    logic [23:0] st;
    stuck1_en = 1'b1;
    run_big(-10, done_k, busy_bad, st);
    stuck1_en = 1'b0;
    total++;
    if (done_k != 5121 || bif.FAIL !== 1'b1 || bif.FAIL_ADDR !== 9'h1A3 || bif.FAIL_ELEM !== 3'd1 || bif.ERR_CNT !== 8'd3) begin
      bad++; $display("FAIL stuck1: done=%0d fail=%b addr=%h elem=%0d err=%0d want 5121 1 1a3 1 3",
        done_k, bif.FAIL, bif.FAIL_ADDR, bif.FAIL_ELEM, bif.ERR_CNT);
    end
  endtask

  task automatic test_stuck0_saturate;
    int done_k, busy_bad;
    logic [23:0] st;
    stuck0_en = 1'b1;
    run_big(-10, done_k, busy_bad, st);
    stuck0_en = 1'b0;
    total++;
    if (done_k != 5121 || bif.FAIL !== 1'b1 || bif.FAIL_ADDR !== 9'h000 || bif.FAIL_ELEM !== 3'd2 || bif.ERR_CNT !== 8'd255) begin
      bad++; $display("FAIL stuck0: done=%0d fail=%b addr=%h elem=%0d err=%0d want 5121 1 000 2 255",
        done_k, bif.FAIL, bif.FAIL_ADDR, bif.FAIL_ELEM, bif.ERR_CNT);
    end
  endtask

  task automatic test_back_to_back_rerun;
    int done_k, busy_bad;
    logic [23:0] st;
    run_big(-10, done_k, busy_bad, st);
    // DONE, BUSY, FAIL, FAIL_ADDR, FAIL_ELEM, ERR_CNT just after E0
    total++;
    if (st !== {1'b0, 1'b1, 1'b0, 9'd0, 3'd0, 8'd0}) begin
      bad++; $display("FAIL rerun_clear: got %h want %h", st, {1'b0, 1'b1, 1'b0, 9'd0, 3'd0, 8'd0});
    end
    total++;
    if (done_k != 5121 || bif.FAIL !== 1'b0 || bif.ERR_CNT !== 8'd0) begin
      bad++; $display("FAIL rerun_result: done=%0d fail=%b err=%0d want 5121 0 0", done_k, bif.FAIL, bif.ERR_CNT);
    end
  endtask

  task automatic test_start_ignored;
    int done_k, busy_bad;
    logic [23:0] st;
    run_big(50, done_k, busy_bad, st);
    total++;
    if (done_k != 5121 || busy_bad != 0 || bif.FAIL !== 1'b0) begin
      bad++; $display("FAIL start_ignored: done=%0d busy_bad=%0d fail=%b want 5121 0 0", done_k, busy_bad, bif.FAIL);
    end
  endtask

  task automatic test_reset_midrun;
    int m0;
    @(negedge clk);
    bif.START = 1'b1;
    @(posedge clk); #1;
    bif.START = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bif.BUSY, bif.DONE, bif.FAIL, bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN,
         bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM, bif.ERR_CNT} !== 153'd0) begin
      bad++; $display("FAIL midrun_reset_outputs: busy=%b en=%b men=%b addr=%0h bm=%h want all 0",
        bif.BUSY, bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_ADDR, bif.A_BIST_BM);
    end
    m0 = men_cnt;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    total++;
    if (men_cnt != m0 || bif.BUSY !== 1'b0) begin
      bad++; $display("FAIL midrun_no_men: got %0d ops busy=%b want 0 0", men_cnt - m0, bif.BUSY);
    end
  endtask

  task automatic test_small_variant;
    int k, done_k, m0;
    m0 = men_s;
    @(negedge clk);
    sif.START = 1'b1;
    @(posedge clk); #1;
    sif.START = 1'b0;
    k = 0; done_k = -1;
    while (k < 400) begin
      @(posedge clk); #1;
      k++;
      if (sif.DONE) begin done_k = k; break; end
    end
    total++;
    if (done_k != 161 || sif.FAIL !== 1'b0 || sif.ERR_CNT !== 8'd0 || men_s - m0 != 160) begin
      bad++; $display("FAIL small_variant: done=%0d fail=%b err=%0d ops=%0d want 161 0 0 160",
        done_k, sif.FAIL, sif.ERR_CNT, men_s - m0);
    end
  endtask

  initial begin
    bif.START = 1'b0;
    sif.START = 1'b0;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_fault_free();
    test_stuck1();
    test_stuck0_saturate();
    test_back_to_back_rerun();
    test_start_ignored();
    test_reset_midrun();
    test_small_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
